interval_timer_ctrl: RTL and testbench

//   Command-driven controller that sequences a free-running up-counter: load terminal value,

---
 rtl/interval_timer_ctrl.sv | 136 +++++++++++++
 tb/tb_interval_timer_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/interval_timer_ctrl.sv
// Command-driven interval timer: prescaled up-counter with terminal match,
// one-shot or periodic operation, and a single-cycle registered match pulse.
//
//   state | meaning
//   IDLE  | stopped; LOAD/CLEAR reset count, START begins counting
//   RUN   | counting on prescaler ticks; busy=1
//   PAUSE | counting suspended; count and prescaler held
//   DONE  | one-shot finished; commands refused for this single cycle
module interval_timer_ctrl #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [WIDTH-1:0]      cmd_data,
  input  logic                  periodic,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  match
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t                state;
  logic [WIDTH-1:0]      terminal;
  logic [PRESCALE_W-1:0] prescaler;
  logic [PRESCALE_W-1:0] prescale_l;
  logic                  periodic_l;
  logic                  accept;
  logic                  tick;

  assign cmd_ready = (state != DONE);
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = (state == RUN) && (prescaler == prescale_l);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      terminal   <= '1;
      prescaler  <= '0;
      prescale_l <= '0;
      periodic_l <= 1'b0;
      busy       <= 1'b0;
      match      <= 1'b0;
    end else begin
      match <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (cmd_op)
              OP_LOAD: begin
                terminal <= cmd_data;
                count    <= '0;
              end
              OP_START: begin
                state      <= RUN;
                busy       <= 1'b1;
                prescaler  <= '0;
                periodic_l <= periodic;
                prescale_l <= prescale;
              end
              OP_CLEAR: count <= '0;
              default: ;
            endcase
          end
        end
        RUN: begin
          // An accepted command swallows a coincident tick: no increment, no match.
          if (accept) begin
            case (cmd_op)
              OP_STOP: begin
                state <= PAUSE;
                busy  <= 1'b0;
              end
              OP_CLEAR: begin
                count     <= '0;
                prescaler <= '0;
              end
              OP_LOAD: begin
                terminal  <= cmd_data;
                prescaler <= tick ? '0 : prescaler + 1'b1;
              end
              default: prescaler <= tick ? '0 : prescaler + 1'b1;
            endcase
          end else if (tick) begin
            prescaler <= '0;
            if (count != terminal) begin
              count <= count + 1'b1;
            end else begin
              match <= 1'b1;
              if (periodic_l) begin
                count <= '0;
              end else begin
                state <= DONE;
                busy  <= 1'b0;
              end
            end
          end else begin
            prescaler <= prescaler + 1'b1;
          end
        end
        PAUSE: begin
          if (accept) begin
            case (cmd_op)
              OP_START: begin
                state      <= RUN;
                busy       <= 1'b1;
                periodic_l <= periodic;
                prescale_l <= prescale;
              end
              OP_CLEAR: begin
                state     <= IDLE;
                count     <= '0;
                prescaler <= '0;
              end
              OP_LOAD: terminal <= cmd_data;
              default: ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed and randomized bench for interval_timer_ctrl, checked cycle by cycle
// against a behavioural model of the timer.
module tb_interval_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic       periodic;
  logic [3:0] prescale;
  logic [3:0] count;
  logic       busy;
  logic       match;

  int errors = 0;
  int checks = 0;

  // model: activity flags, counter, terminal, prescaler position/limit, mode
  bit m_run, m_pause, m_done, m_match, m_per;
  int m_cnt, m_term, m_psc, m_plim;

  localparam logic [1:0] LOAD = 2'b00, START = 2'b01, STOP = 2'b10, CLEAR = 2'b11;

  interval_timer_ctrl #(.WIDTH(4), .PRESCALE_W(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .periodic(periodic), .prescale(prescale),
    .count(count), .busy(busy), .match(match)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_step(input bit r, input bit v, input bit [1:0] op,
                                     input int d, input bit per, input int pre);
    bit acc, t;
    if (r) begin
      m_run = 0; m_pause = 0; m_done = 0; m_match = 0; m_per = 0;
      m_cnt = 0; m_term = 15; m_psc = 0; m_plim = 0;
      return;
    end
    acc = v && !m_done;
    m_match = 0;
    if (m_done) begin
      m_done = 0;
    end else if (m_run) begin
      t = (m_psc == m_plim);
      if (acc) begin
        if (op == STOP) begin
          m_run = 0; m_pause = 1;
        end else if (op == CLEAR) begin
          m_cnt = 0; m_psc = 0;
        end else begin
          if (op == LOAD) m_term = d;
          m_psc = t ? 0 : (m_psc + 1) % 16;
        end
      end else if (t) begin
        m_psc = 0;
        if (m_cnt == m_term) begin
          m_match = 1;
          if (m_per) m_cnt = 0;
          else begin
            m_run = 0; m_done = 1;
          end
        end else begin
          m_cnt = (m_cnt + 1) % 16;
        end
      end else begin
        m_psc = (m_psc + 1) % 16;
      end
    end else if (m_pause) begin
      if (acc && op == START) begin
        m_pause = 0; m_run = 1; m_per = per; m_plim = pre;
      end else if (acc && op == CLEAR) begin
        m_pause = 0; m_cnt = 0; m_psc = 0;
      end else if (acc && op == LOAD) begin
        m_term = d;
      end
    end else if (acc) begin
      if (op == LOAD) begin
        m_term = d; m_cnt = 0;
      end else if (op == START) begin
        m_run = 1; m_psc = 0; m_per = per; m_plim = pre;
      end else if (op == CLEAR) begin
        m_cnt = 0;
      end
    end
  endfunction

  task automatic cyc(input bit r, input bit v, input bit [1:0] op, input int d,
                     input bit per, input int pre);
    @(negedge clk);
    reset = r; cmd_valid = v; cmd_op = op; cmd_data = 4'(d);
    periodic = per; prescale = 4'(pre);
    #1 chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, !m_done});
    @(posedge clk);
    model_step(r, v, op, d, per, pre);
    #1;
    chk("count", {28'd0, count}, 32'(m_cnt));
    chk("busy", {31'd0, busy}, {31'd0, m_run});
    chk("match", {31'd0, match}, {31'd0, m_match});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, LOAD, 0, 0, 0);
  endtask

  task automatic cmd(input bit [1:0] op, input int d, input bit per, input int pre);
    cyc(0, 1, op, d, per, pre);
  endtask

  task automatic run_until(input int target, input int budget);
    for (int i = 0; i < budget && m_cnt != target; i++) idle(1);
    chk("wait_count", 32'(m_cnt), 32'(target));
  endtask

  initial begin
    reset = 1; cmd_valid = 0; cmd_op = 0; cmd_data = 0; periodic = 0; prescale = 0;
    model_step(1, 0, 0, 0, 0, 0);
    cyc(1, 0, LOAD, 0, 0, 0);
    cyc(1, 0, LOAD, 0, 0, 0);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);

    // one-shot to 5 at full rate
    cmd(LOAD, 5, 0, 0);
    cmd(START, 0, 0, 0);
    chk("t1_start_cnt", {28'd0, count}, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      idle(1);
      chk("t1_cnt", {28'd0, count}, 32'(i));
    end
    idle(1);
    chk("t1_match", {31'd0, match}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    chk("t1_ready_low", {31'd0, cmd_ready}, 32'd0);
    idle(3);
    chk("t1_hold", {28'd0, count}, 32'd5);

    // periodic terminal 3, prescale 1: match every 8 clocks
    cmd(LOAD, 3, 0, 0);
    cmd(START, 0, 1, 1);
    idle(20);

    // pause at 2, resume
    run_until(2, 40);
    cmd(STOP, 0, 0, 0);
    idle(10);
    chk("t3_paused_cnt", {28'd0, count}, 32'd2);
    cmd(START, 0, 1, 1);
    idle(6);

    // reset mid-run with a command present
    cyc(1, 0, LOAD, 0, 0, 0);
    cmd(LOAD, 15, 0, 0);
    cmd(START, 0, 0, 0);
    run_until(7, 20);
    cyc(1, 1, LOAD, 3, 0, 0);
    chk("t4_rst_cnt", {28'd0, count}, 32'd0);
    cmd(START, 0, 0, 0);
    idle(20);

    // LOAD below current count wraps before matching
    cmd(LOAD, 9, 0, 0);
    cmd(START, 0, 0, 0);
    run_until(6, 20);
    cmd(LOAD, 2, 0, 0);
    idle(16);

    // CLEAR coincident with terminal tick, then continuous match
    cyc(1, 0, LOAD, 0, 0, 0);
    cmd(LOAD, 3, 0, 0);
    cmd(START, 0, 1, 0);
    run_until(3, 20);
    cmd(CLEAR, 0, 0, 0);
    chk("t6_no_match", {31'd0, match}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd1);
    cmd(STOP, 0, 0, 0);
    cmd(CLEAR, 0, 0, 0);
    cmd(LOAD, 0, 0, 0);
    cmd(START, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("t6_match_hi", {31'd0, match}, 32'd1);
    end

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit r, v;
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 99) < 25);
      cyc(r, v, 2'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
